// File: rtl/byte_pkg.sv
// Shared constants, opcode encodings and the instruction decoder for the
// byte_unit execution pipe.
package byte_pkg;

    localparam int QW_W      = 128;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 16;
    localparam int NUM_WORDS = 4;

    localparam logic [10:0] OP_CNTB  = 11'b01010110100;
    localparam logic [10:0] OP_AVGB  = 11'b00011010011;
    localparam logic [10:0] OP_ABSDB = 11'b00001010011;
    localparam logic [10:0] OP_SUMB  = 11'b01001010011;

    localparam logic [2:0]  FMT_RR   = 3'b000;

    typedef enum logic [1:0] {
        SEL_CNTB  = 2'd0,
        SEL_AVGB  = 2'd1,
        SEL_ABSDB = 2'd2,
        SEL_SUMB  = 2'd3
    } op_sel_e;

    typedef struct packed {
        logic    valid;
        op_sel_e sel;
    } dec_t;

    // Anything not RR-format or not one of the four opcodes decodes as invalid.
    function automatic dec_t decode_op(input logic [10:0] op, input logic [2:0] fmt);
        dec_t d;
        logic known;
        known = 1'b1;
        d.sel = SEL_CNTB;
        case (op)
            OP_CNTB:  d.sel = SEL_CNTB;
            OP_AVGB:  d.sel = SEL_AVGB;
            OP_ABSDB: d.sel = SEL_ABSDB;
            OP_SUMB:  d.sel = SEL_SUMB;
            default:  known = 1'b0;
        endcase
        d.valid = known & (fmt == FMT_RR);
        return d;
    endfunction

endpackage

// File: rtl/byte_unit_if.sv
// Instruction-issue and write-back signal bundle of byte_unit.
interface byte_unit_if;
    import byte_pkg::*;

    logic [10:0]     op_code;
    logic [2:0]      instr_format;
    logic [6:0]      dest_reg_addr;
    logic [QW_W-1:0] src_reg_a;
    logic [QW_W-1:0] src_reg_b;
    logic [17:0]     imm_value;
    logic            enable_reg_write;
    logic            branch_is_taken;
    logic [QW_W-1:0] wb_data;
    logic [6:0]      wb_reg_addr;
    logic            wb_enable_reg_write;
    logic [6:0]      delayed_rt_addr;
    logic            delayed_enable_reg_write;

    modport master (
        output op_code, instr_format, dest_reg_addr, src_reg_a, src_reg_b,
               imm_value, enable_reg_write, branch_is_taken,
        input  wb_data, wb_reg_addr, wb_enable_reg_write,
               delayed_rt_addr, delayed_enable_reg_write
    );

    modport slave (
        input  op_code, instr_format, dest_reg_addr, src_reg_a, src_reg_b,
               imm_value, enable_reg_write, branch_is_taken,
        output wb_data, wb_reg_addr, wb_enable_reg_write,
               delayed_rt_addr, delayed_enable_reg_write
    );

endinterface

// File: rtl/byte_lane.sv
// One combinational 8-bit lane: popcount, rounded average, absolute difference.
module byte_lane (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] cnt_o,
    output logic [7:0] avg_o,
    output logic [7:0] absd_o
);

    logic [3:0] cnt_s;
    logic [8:0] avg_sum_s;

    // Population count of the ra byte.
    always_comb begin
        cnt_s = 4'd0;
        for (int k = 0; k < 8; k++) begin
            cnt_s = cnt_s + {3'b000, a_i[k]};
        end
    end

    assign cnt_o     = {4'b0000, cnt_s};
    assign avg_sum_s = {1'b0, a_i} + {1'b0, b_i} + 9'd1;
    assign avg_o     = avg_sum_s[8:1];
    assign absd_o    = (b_i >= a_i) ? (b_i - a_i) : (a_i - b_i);

endmodule

// File: rtl/byte_unit.sv
// Two-stage byte execution unit: cntb / avgb / absdb / sumb on 128-bit quadwords.
// Byte 0 is the most significant byte of each quadword.
module byte_unit
    import byte_pkg::*;
(
    input logic        clock,
    input logic        reset,
    byte_unit_if.slave bus
);

    logic [QW_W-1:0] cnt_s;
    logic [QW_W-1:0] avg_s;
    logic [QW_W-1:0] absd_s;
    logic [QW_W-1:0] sumb_s;
    logic [QW_W-1:0] result_s;
    dec_t            dec_s;
    logic            unused_imm_s;

    logic [QW_W-1:0] s1_data_d, s1_data_q;
    logic [6:0]      s1_addr_d, s1_addr_q;
    logic            s1_en_d,   s1_en_q;
    logic [QW_W-1:0] wb_data_d, wb_data_q;
    logic [6:0]      wb_addr_d, wb_addr_q;
    logic            wb_en_d,   wb_en_q;

    assign unused_imm_s = ^bus.imm_value;
    assign dec_s        = decode_op(bus.op_code, bus.instr_format);

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
        byte_lane u_lane (
            .a_i    (bus.src_reg_a[QW_W-1-BYTE_W*i -: BYTE_W]),
            .b_i    (bus.src_reg_b[QW_W-1-BYTE_W*i -: BYTE_W]),
            .cnt_o  (cnt_s[QW_W-1-BYTE_W*i -: BYTE_W]),
            .avg_o  (avg_s[QW_W-1-BYTE_W*i -: BYTE_W]),
            .absd_o (absd_s[QW_W-1-BYTE_W*i -: BYTE_W])
        );
    end

    // sumb: per word, even halfword holds the rb byte sum, odd halfword the ra sum.
    always_comb begin
        logic [9:0] sum_a;
        logic [9:0] sum_b;
        sumb_s = 128'd0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            sum_a = 10'd0;
            sum_b = 10'd0;
            for (int k = 0; k < 4; k++) begin
                sum_a = sum_a + {2'b00, bus.src_reg_a[127-32*w-8*k -: 8]};
                sum_b = sum_b + {2'b00, bus.src_reg_b[127-32*w-8*k -: 8]};
            end
            sumb_s[127-32*w -: 16] = {6'b000000, sum_b};
            sumb_s[111-32*w -: 16] = {6'b000000, sum_a};
        end
    end

    // Result select; invalid instructions produce an all-zero result.
    always_comb begin
        result_s = 128'd0;
        if (dec_s.valid) begin
            case (dec_s.sel)
                SEL_CNTB:  result_s = cnt_s;
                SEL_AVGB:  result_s = avg_s;
                SEL_ABSDB: result_s = absd_s;
                SEL_SUMB:  result_s = sumb_s;
                default:   result_s = 128'd0;
            endcase
        end else begin
            result_s = 128'd0;
        end
    end

    // Next-state for both pipeline stages; a taken branch kills only the write enable.
    always_comb begin
        s1_data_d = result_s;
        s1_addr_d = bus.dest_reg_addr;
        s1_en_d   = bus.enable_reg_write & dec_s.valid & ~bus.branch_is_taken;
        wb_data_d = s1_data_q;
        wb_addr_d = s1_addr_q;
        wb_en_d   = s1_en_q;
    end

    // Pipeline registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_data_q <= 128'd0;
            s1_addr_q <= 7'd0;
            s1_en_q   <= 1'b0;
            wb_data_q <= 128'd0;
            wb_addr_q <= 7'd0;
            wb_en_q   <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_addr_q <= s1_addr_d;
            s1_en_q   <= s1_en_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            wb_en_q   <= wb_en_d;
        end
    end

    assign bus.wb_data                  = wb_data_q;
    assign bus.wb_reg_addr              = wb_addr_q;
    assign bus.wb_enable_reg_write      = wb_en_q;
    assign bus.delayed_rt_addr          = s1_addr_q;
    assign bus.delayed_enable_reg_write = s1_en_q;

endmodule

// File: tb/tb_byte_unit.sv
// Self-checking bench for byte_unit: directed test-plan vectors followed by a
// randomized run against a byte-array reference model.
module tb_byte_unit;
    import byte_pkg::*;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    byte_unit_if bus ();

    byte_unit u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference pipeline contents.
    logic [127:0] m_s1_data, m_wb_data;
    logic [6:0]   m_s1_addr, m_wb_addr;
    logic         m_s1_en,   m_wb_en;

    localparam logic [127:0] RA    = 128'h0ABCDEF1_23456789_0ABCDEF1_23456789;
    localparam logic [127:0] RB    = 128'h0FEDCBA0_98765432_1FEDCBA0_98765432;
    localparam logic [127:0] CNT_E = 128'h02050605_03030503_02050605_03030503;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_valid(input logic [10:0] op, input logic [2:0] fmt);
        return (fmt == 3'b000) &&
               (op == OP_CNTB || op == OP_AVGB || op == OP_ABSDB || op == OP_SUMB);
    endfunction

    function automatic logic [127:0] ref_data(input logic [10:0] op, input logic [2:0] fmt,
                                              input logic [127:0] ra, input logic [127:0] rb);
        int a [16];
        int b [16];
        int r;
        logic [127:0] res;
        res = 128'd0;
        for (int i = 0; i < 16; i++) begin
            a[i] = int'(ra[127-8*i -: 8]);
            b[i] = int'(rb[127-8*i -: 8]);
        end
        if (!ref_valid(op, fmt)) return 128'd0;
        if (op == OP_SUMB) begin
            for (int w = 0; w < 4; w++) begin
                int sa, sb;
                sa = a[4*w] + a[4*w+1] + a[4*w+2] + a[4*w+3];
                sb = b[4*w] + b[4*w+1] + b[4*w+2] + b[4*w+3];
                res[127-32*w -: 16] = 16'(sb);
                res[111-32*w -: 16] = 16'(sa);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (op == OP_CNTB) begin
                    r = 0;
                    for (int k = 0; k < 8; k++) r += (a[i] >> k) & 1;
                end else if (op == OP_AVGB) begin
                    r = (a[i] + b[i] + 1) / 2;
                end else begin
                    r = (b[i] > a[i]) ? b[i] - a[i] : a[i] - b[i];
                end
                res[127-8*i -: 8] = 8'(r);
            end
        end
        return res;
    endfunction

    // One rising edge: advance the model, then compare every output 1 time unit later.
    task automatic step();
        logic [127:0] nd;
        logic         ne;
        nd = ref_data(bus.op_code, bus.instr_format, bus.src_reg_a, bus.src_reg_b);
        ne = bus.enable_reg_write & ref_valid(bus.op_code, bus.instr_format) & ~bus.branch_is_taken;
        @(posedge clock);
        if (!reset) begin
            m_wb_data = 128'd0; m_wb_addr = 7'd0; m_wb_en = 1'b0;
            m_s1_data = 128'd0; m_s1_addr = 7'd0; m_s1_en = 1'b0;
        end else begin
            m_wb_data = m_s1_data; m_wb_addr = m_s1_addr; m_wb_en = m_s1_en;
            m_s1_data = nd; m_s1_addr = bus.dest_reg_addr; m_s1_en = ne;
        end
        #1;
        check_val("wb_data",   bus.wb_data,                           m_wb_data);
        check_val("wb_addr",   {121'd0, bus.wb_reg_addr},             {121'd0, m_wb_addr});
        check_val("wb_en",     {127'd0, bus.wb_enable_reg_write},     {127'd0, m_wb_en});
        check_val("s1_addr",   {121'd0, bus.delayed_rt_addr},         {121'd0, m_s1_addr});
        check_val("s1_en",     {127'd0, bus.delayed_enable_reg_write},{127'd0, m_s1_en});
    endtask

    task automatic issue(input logic [10:0] op, input logic [2:0] fmt,
                         input logic [127:0] ra, input logic [127:0] rb,
                         input logic [6:0] dest, input logic en, input logic br);
        bus.op_code          = op;
        bus.instr_format     = fmt;
        bus.src_reg_a        = ra;
        bus.src_reg_b        = rb;
        bus.dest_reg_addr    = dest;
        bus.enable_reg_write = en;
        bus.branch_is_taken  = br;
        bus.imm_value        = 18'($urandom);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_s1_data = 128'd0; m_s1_addr = 7'd0; m_s1_en = 1'b0;
        m_wb_data = 128'd0; m_wb_addr = 7'd0; m_wb_en = 1'b0;
        reset = 1'b0;
        issue(OP_CNTB, 3'b000, RA, RB, 7'd3, 1'b1, 1'b0);
        step();
        step();
        check_val("rst_wb_data", bus.wb_data, 128'd0);
        check_val("rst_wb_en",   {127'd0, bus.wb_enable_reg_write}, 128'd0);

        // Back-to-back cntb, avgb, absdb, sumb.
        reset = 1'b1;
        step();
        issue(OP_AVGB, 3'b000, RA, RB, 7'd3, 1'b1, 1'b0);
        step();
        check_val("cntb_data", bus.wb_data, CNT_E);
        check_val("cntb_addr", {121'd0, bus.wb_reg_addr}, 128'd3);
        check_val("cntb_en",   {127'd0, bus.wb_enable_reg_write}, 128'd1);
        issue(OP_ABSDB, 3'b000, RA, RB, 7'd3, 1'b1, 1'b0);
        step();
        check_val("avgb_b01", {112'd0, bus.wb_data[127:112]}, 128'h0DD5);
        issue(OP_SUMB, 3'b000, RA, RB, 7'd3, 1'b1, 1'b0);
        step();
        check_val("absdb_b01", {112'd0, bus.wb_data[127:112]}, 128'h0531);
        issue(11'd0, 3'b000, RA, RB, 7'd3, 1'b1, 1'b0);
        step();
        check_val("sumb_w0", {96'd0, bus.wb_data[127:96]}, 128'h02670295);
        issue(OP_CNTB, 3'b001, RA, RB, 7'd3, 1'b1, 1'b0);
        step();
        check_val("nop_data", bus.wb_data, 128'd0);
        check_val("nop_en",   {127'd0, bus.wb_enable_reg_write}, 128'd0);
        issue(OP_CNTB, 3'b000, RA, RB, 7'd3, 1'b1, 1'b1);
        step();
        check_val("fmt_en", {127'd0, bus.wb_enable_reg_write}, 128'd0);
        check_val("br_s1_en", {127'd0, bus.delayed_enable_reg_write}, 128'd0);
        issue(OP_SUMB, 3'b000, {128{1'b1}}, {128{1'b1}}, 7'd9, 1'b1, 1'b0);
        step();
        check_val("br_wb_en", {127'd0, bus.wb_enable_reg_write}, 128'd0);
        issue(11'd0, 3'b000, RA, RB, 7'd0, 1'b0, 1'b0);
        step();
        check_val("sumb_ff", bus.wb_data, {8{16'h03FC}});

        // Reset held while valid ops stream in, then first op after release.
        reset = 1'b0;
        issue(OP_AVGB, 3'b000, RA, RB, 7'd4, 1'b1, 1'b0);
        step();
        issue(OP_SUMB, 3'b000, RA, RB, 7'd6, 1'b1, 1'b0);
        step();
        check_val("hold_wb_data", bus.wb_data, 128'd0);
        check_val("hold_s1_addr", {121'd0, bus.delayed_rt_addr}, 128'd0);
        reset = 1'b1;
        issue(OP_CNTB, 3'b000, RA, RB, 7'd5, 1'b1, 1'b0);
        step();
        check_val("post_rst_s1_wb_en", {127'd0, bus.wb_enable_reg_write}, 128'd0);
        issue(11'd0, 3'b000, RA, RB, 7'd0, 1'b0, 1'b0);
        step();
        check_val("post_rst_data", bus.wb_data, CNT_E);
        check_val("post_rst_addr", {121'd0, bus.wb_reg_addr}, 128'd5);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [10:0] op;
            logic [2:0]  fmt;
            case ($urandom_range(0, 5))
                0: op = OP_CNTB;
                1: op = OP_AVGB;
                2: op = OP_ABSDB;
                3: op = OP_SUMB;
                4: op = 11'd0;
                default: op = 11'($urandom);
            endcase
            fmt   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            reset = ($urandom_range(0, 24) != 0);
            issue(op, fmt, {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 7'($urandom),
                  1'($urandom), ($urandom_range(0, 5) == 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/byte_unit.md
# byte_unit

Byte-granular execution unit of the SPU odd/even pipeline (module `byte_unit`). It takes a decoded RR-format instruction and its operands from the register-file/forwarding stage and performs one of four byte operations on 128-bit quadwords: `cntb`, `avgb`, `absdb` or `sumb`. It returns the result, destination address and write enable to the write-back stage two clock cycles later. Bit 0 is the MSB throughout; byte *i* is bits [8i:8i+7].

## Interface
Parameters: none.
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low; sampled on rising clock edge
- op_code  in  11  decoded opcode, truncated per format
- instr_format  in  3  instruction format; only 3'b000 (RR) is executed
- dest_reg_addr  in  7  destination register (rt)
- src_reg_a  in  128  ra value
- src_reg_b  in  128  rb value
- imm_value  in  18  immediate; unused by this unit
- enable_reg_write  in  1  instruction writes the register table
- wb_data  out  128  stage-2 result
- wb_reg_addr  out  7  destination of wb_data
- wb_enable_reg_write  out  1  wb_data is to be written
- branch_is_taken  in  1  squashes the instruction currently entering stage 1
- delayed_rt_addr  out  7  stage-1 destination address (forwarding/hazard visibility)
- delayed_enable_reg_write  out  1  stage-1 write enable

## Operation
Opcodes (11-bit, MSB first); all operate per element, unsigned:
- `cntb` 01010110100: each result byte = popcount of the corresponding ra byte (range 0..8).
- `avgb` 00011010011: each byte = (ra + rb + 1) >> 1, computed at 9 bits, truncated to 8.
- `absdb` 00001010011: each byte = |rb − ra|.
- `sumb` 00110100101 is **not** valid. `sumb` is 01001010011. For each word w = 0..3:
  - result halfword 2w = sum of the 4 rb bytes of word w;
  - result halfword 2w+1 = sum of the 4 ra bytes of word w;
  - each sum is zero-extended to 16 bits (max 1020).
- Any other op_code, or instr_format ≠ 000 (including nop = 0): result = 0 and write enable = 0.
- branch_is_taken = 1: the stage-1 write enable is forced to 0. The address and data still propagate.
- imm_value is ignored.

## Timing
- Stage 1 register, at clock edge N:
  - delayed_rt_data ← result;
  - delayed_rt_addr ← dest_reg_addr;
  - delayed_enable_reg_write ← enable_reg_write & valid_op & ~branch_is_taken.
- Stage 2 register, at edge N+1: wb_data, wb_reg_addr and wb_enable_reg_write ← the stage-1 values.
- Latency is 2 cycles from input sample to write-back outputs. Throughput is one instruction per cycle, with no stalls and no handshake.
- Reset: when reset = 0 at a rising edge, every register clears to 0. This covers wb_data, wb_reg_addr, wb_enable_reg_write, delayed_rt_addr and delayed_enable_reg_write.
  - Any in-flight instruction is discarded.
  - The first instruction sampled after reset deasserts appears on the wb_* outputs 2 edges later.
- Outputs are purely registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `byte_pkg`:
  - opcode localparams OP_CNTB, OP_AVGB, OP_ABSDB, OP_SUMB;
  - format constant FMT_RR = 3'b000;
  - quadword/byte width constants.
- Sub-module `byte_lane`: a combinational 8-bit lane producing popcount, average and absolute difference. It is instantiated 16 times.
- The `sumb` adder trees and the two pipeline stages live in the top level.

## Test plan
Common operands for these tests:
- ra = 0x0ABCDEF1_23456789_0ABCDEF1_23456789
- rb = 0x0FEDCBA0_98765432_1FEDCBA0_98765432
- dest = 3, enable = 1, format = 000, branch = 0

1. `cntb` → after 2 edges, wb_data = 0x02050605_03030503_02050605_03030503, wb_reg_addr = 3, wb_enable = 1.
2. `avgb` → wb_data byte0 = 0x0D, byte1 = 0xD5. `absdb` → byte0 = 0x05, byte1 = 0x31.
3. `sumb` → wb_data word0 = 0x0267_0295. Issue back-to-back with 1 and 2 (one opcode per cycle); the results must appear in order on consecutive cycles.
4. op_code = 0 (nop) → wb_data = 0, wb_enable = 0 two cycles later. Also instr_format = 001 with op `cntb` → wb_enable = 0.
5. `cntb` with branch_is_taken = 1 → delayed_enable_reg_write = 0 after 1 edge, wb_enable = 0 after 2. Also ra = all 0xFF, rb = all 0xFF with `sumb` → every halfword = 0x03FC.
6. reset = 0 held across 2 edges while valid ops stream in → all outputs 0. Deassert reset → the first post-reset op appears exactly 2 edges later.
